// File: rtl/riscv_ifetch_pkg.sv
// rtl/riscv_ifetch_pkg.sv - shared state enum, NOP constant and prefetch entry type for riscv_ifetch
package riscv_ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } ifetch_state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int unsigned IFETCH_PC_W = 32;

  typedef struct packed {
    logic [IFETCH_PC_W-1:0] pc;
    logic [31:0]            instr;
  } ifetch_entry_t;

endpackage

// File: rtl/riscv_ifetch_fifo.sv
// rtl/riscv_ifetch_fifo.sv - synchronous prefetch FIFO; flush wins over push and pop
module riscv_ifetch_fifo
  import riscv_ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = ifetch_entry_t
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_flush,
  input  T     i_data,
  output logic o_full,
  output logic o_empty,
  output T     o_head
);

  localparam int unsigned     AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_wr_en;
  logic           w_rd_en;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_wr_en = i_push & !o_full & !i_flush;
  assign w_rd_en = i_pop & !o_empty & !i_flush;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is only looked at when the count is non-zero.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/riscv_ifetch.sv
// rtl/riscv_ifetch.sv - instruction fetch stage with prefetch FIFO and redirect flush
// Optional fetch/bubble counters are built when IFETCH_PERF_EN is defined.
module riscv_ifetch
  import riscv_ifetch_pkg::*;
#(
  parameter int unsigned       WIDTH      = 32,
  parameter logic [WIDTH-1:0]  RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              master_clk,
  input  logic              master_nrst,
  output logic              imem_req,
  output logic [WIDTH-1:0]  imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [WIDTH-1:0]  redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instruction,
  output logic [WIDTH-1:0]  pc_current
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [31:0]      instr;
  } entry_t;

  ifetch_state_t     r_state;
  logic [WIDTH-1:0]  r_fetch_pc;
  logic [WIDTH-1:0]  r_drop_addr;

  logic              w_full;
  logic              w_empty;
  logic              w_ack;
  logic              w_push;
  logic              w_pop;
  logic [WIDTH-1:0]  w_redirect_pc;
  logic              w_unused_pc_lsb;
  entry_t            w_push_entry;
  entry_t            w_head;

  assign imem_req  = (r_state == FETCH) ? !w_full : (r_state == DROP);
  // DROP keeps presenting the stale address so a redirect cannot disturb the pending request.
  assign imem_addr = (r_state == DROP) ? r_drop_addr : r_fetch_pc;

  assign w_ack           = imem_req & imem_ack;
  assign w_push          = (r_state == FETCH) & w_ack & !redirect_valid;
  assign w_pop           = instr_valid & instr_ready;
  assign w_redirect_pc   = {redirect_pc[WIDTH-1:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc[1:0];

  assign w_push_entry.pc    = r_fetch_pc;
  assign w_push_entry.instr = imem_rdata;

  assign instr_valid = !w_empty;
  assign instruction = w_empty ? NOP : w_head.instr;
  assign pc_current  = w_empty ? r_fetch_pc : w_head.pc;

  always_ff @(posedge master_clk or negedge master_nrst) begin
    if (!master_nrst) begin
      r_state     <= IDLE;
      r_fetch_pc  <= RESET_PC;
      r_drop_addr <= RESET_PC;
    end else begin
      if (redirect_valid)  r_fetch_pc <= w_redirect_pc;
      else if (w_push)     r_fetch_pc <= r_fetch_pc + WIDTH'(4);
      case (r_state)
        IDLE:    r_state <= FETCH;
        FETCH: begin
          if (redirect_valid && imem_req && !imem_ack) begin
            r_state     <= DROP;
            r_drop_addr <= r_fetch_pc;
          end
        end
        DROP:    if (imem_ack) r_state <= FETCH;
        default: r_state <= IDLE;
      endcase
    end
  end

  riscv_ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .i_clk   (master_clk),
    .i_rst_n (master_nrst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_push_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_bubbles;

  always_ff @(posedge master_clk or negedge master_nrst) begin
    if (!master_nrst) begin
      r_perf_fetched <= '0;
      r_perf_bubbles <= '0;
    end else begin
      if (w_pop)                       r_perf_fetched <= r_perf_fetched + 32'd1;
      if (instr_ready && !instr_valid) r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`endif

endmodule
